seq_mult32: RTL and testbench
=============================

# seq_mult32

Sequential unsigned 32x32 shift-add multiplier that drives the 32-bit ripple adder stage of the classic multiplier datapath. Each cycle it presents the running upper partial product and the gated multiplicand to a 33-bit add (32-bit ripple sum plus captured carry), then shifts right. It delivers a 64-bit product after 32 iterations. A start/busy/done handshake connects it to the issuing control logic.

## Interface
- No parameters; width fixed at 32x32 -> 64.
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  asynchronous active-low reset.
- A  input  32  multiplicand, sampled only on an accepted start.
- B  input  32  multiplier, sampled only on an accepted start.
- start  input  1  request; accepted only on an edge where state is IDLE.
- busy  output  1  high while an operation is in progress (state RUN).
- done  output  1  single-cycle pulse; P is valid from this cycle on.
- P  output  64  product; held until the next completion or reset.

## Operation
- States:
  - IDLE -> RUN when start=1 at an edge.
  - RUN -> IDLE when the iteration count reaches 31 at an edge.
  - No other transitions.
- On accept:
  - Register M<=A.
  - Load accumulator hi<=0, lo<=B.
  - Clear count<=0.
- Each RUN edge:
  - sum33 = {1'b0,hi} + (lo[0] ? {1'b0,M} : 33'd0).
  - hi <= sum33[32:1]; lo <= {sum33[0], lo[31:1]}; count <= count+1.
- The carry out of the 32-bit add is always kept in sum33[32]; the 32-bit add must never drop it.
- On the final (32nd) iteration edge:
  - P <= {sum33[32:1], sum33[0], lo[31:1]}, i.e. the post-shift accumulator.
  - done <= 1 and state <= IDLE.
- done clears on the next edge unconditionally.
- Arithmetic is unsigned. No early termination: zero operands still take 32 iterations.
- start while busy is ignored: no queuing, no effect on M or the accumulator, no error flag.
- A and B may change freely after accept without affecting the result.

## Timing
- Reset (async, immediate on rst_n low): state=IDLE, busy=0, done=0, P=0, M=0, hi=0, lo=0, count=0.
- Reset assertion mid-RUN aborts the operation. No done pulse is produced; P returns to 0.
- Deassertion is synchronised externally. The first edge after release may accept start.
- Start accepted at edge k:
  - busy=1 from edge k through edge k+32.
  - At edge k+32, busy=0, done=1, and P updates.
  - done drops at edge k+33.
- Latency: 32 cycles from the accept edge to done.
- Throughput: one result per 33 cycles.
- start high at edge k+32 is ignored because state is still RUN. start high at edge k+33 is accepted; done is concurrently low.
- start held high continuously gives back-to-back operations, with each accept one cycle after each done.
- P is stable and valid from the done cycle until the next completion edge, and remains readable during a following RUN.

## Test plan
- Reset, then idle with start=0 -> busy=0, done=0, P=0x0000000000000000 indefinitely.
- A=3, B=5, 1-cycle start pulse -> busy high for 32 cycles. done pulses exactly once at accept+32 with P=0x000000000000000F.
- A=0xFFFFFFFF, B=0xFFFFFFFF -> P=0xFFFFFFFE00000001 (exercises carry capture every iteration). Also A=0x80000000, B=2 -> P=0x0000000100000000.
- Start held high, alternating pairs (0,0xDEADBEEF) then (0x12345678,0x10) -> P=0 then P=0x0000000123456780. Accepts land at done-edge+1. Mid-RUN changes on A/B/start must not alter either result.
- Start A=7,B=9, then assert rst_n low at accept+10 -> immediate busy=0, done=0, P=0. After release, start A=7,B=9 -> P=0x000000000000003F at accept+32.
- Randomised 1000 operand pairs, including 0 and all-ones, against a 64-bit reference model. Check the exact done cycle, P, and that done never exceeds one cycle.

Source files
------------

// File: rtl/seq_mult32_if.sv
// Operand/result bundle between the issuing control logic and the multiplier.
// The master issues A/B/start; the slave returns busy/done/P.
interface seq_mult32_if;
  logic [31:0] A;
  logic [31:0] B;
  logic        start;
  logic        busy;
  logic        done;
  logic [63:0] P;

  modport master (output A, B, start, input busy, done, P);
  modport slave  (input A, B, start, output busy, done, P);
endinterface

// File: rtl/seq_mult32.sv
// Unsigned 32x32 shift-add multiplier; 32 cycles from accepted start to done, one result per 33 cycles.
// start is accepted only in IDLE; requests while busy are dropped, never queued.
module seq_mult32 (
  input  logic         clk,
  input  logic         rst_n,
  seq_mult32_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        accept;
  logic        last;

  logic [31:0] m_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [4:0]  count_q;
  logic        done_q;
  logic [63:0] p_q;
  logic [32:0] sum33;

  // Carry of the 32-bit add lands in sum33[32] and shifts into hi[31].
  assign sum33 = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : 33'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          accept  = 1'b1;
        end
      end
      RUN: begin
        if (count_q == 5'd31) begin
          state_d = IDLE;
          last    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      count_q <= 5'd0;
      done_q  <= 1'b0;
      p_q     <= 64'd0;
    end else begin
      done_q <= last;
      if (accept) begin
        m_q     <= bus.A;
        hi_q    <= 32'd0;
        lo_q    <= bus.B;
        count_q <= 5'd0;
      end else if (state_q == RUN) begin
        hi_q    <= sum33[32:1];
        lo_q    <= {sum33[0], lo_q[31:1]};
        count_q <= count_q + 5'd1;
        if (last) begin
          p_q <= {sum33[32:1], sum33[0], lo_q[31:1]};
        end
      end
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.P    = p_q;

endmodule

// File: tb/tb_seq_mult32.sv
// Directed and randomised checks of seq_mult32 timing, product values and reset abort.
module tb_seq_mult32;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  seq_mult32_if bus ();

  seq_mult32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation and observe 35 cycles after the accept edge.
  // Observation index j means "sampled after edge accept+j".
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit scramble,
                        output logic [63:0] p, output int done_at, output int done_cycles,
                        output int busy_bad);
    p           = 64'hx;
    done_at     = -1;
    done_cycles = 0;
    busy_bad    = 0;
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    for (int j = 0; j <= 34; j++) begin
      @(negedge clk);
      if (bus.done) begin
        done_cycles++;
        if (done_at < 0) begin
          done_at = j;
          p       = bus.P;
        end
      end
      if (bus.busy !== (j < 32)) busy_bad++;
      if (scramble && j < 31) begin
        bus.A     = $urandom;
        bus.B     = $urandom;
        bus.start = 1'($urandom_range(0, 1));
      end else begin
        bus.start = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
    bus.start = 1'b0;
    #12;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.P !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b done=%b P=%h, want 0 0 0", bus.busy, bus.done, bus.P);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.P !== 64'd0) begin
        miscompares++;
        $display("FAIL idle_cycle%0d: busy=%b done=%b P=%h, want 0 0 0", i, bus.busy, bus.done, bus.P);
      end
    end
  endtask

  task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] want, input bit scramble);
    logic [63:0] p;
    int done_at, done_cycles, busy_bad;
    run_op(a, b, scramble, p, done_at, done_cycles, busy_bad);
    vectors++;
    if (p !== want) begin
      miscompares++;
      $display("FAIL %s_p: got %h want %h", name, p, want);
    end
    vectors++;
    if (done_at != 32) begin
      miscompares++;
      $display("FAIL %s_done_at: got %0d want 32", name, done_at);
    end
    vectors++;
    if (done_cycles != 1) begin
      miscompares++;
      $display("FAIL %s_done_width: got %0d want 1", name, done_cycles);
    end
    vectors++;
    if (busy_bad != 0) begin
      miscompares++;
      $display("FAIL %s_busy: %0d bad cycles, want 0", name, busy_bad);
    end
  endtask

  task automatic test_basic;
    check_op("mul_3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0);
  endtask

  task automatic test_carry;
    check_op("mul_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
    check_op("mul_msb", 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 1'b1);
  endtask

  task automatic test_back_to_back;
    int done_count;
    int first_done;
    int second_done;
    logic [63:0] p1;
    logic [63:0] p2;
    done_count  = 0;
    first_done  = -1;
    second_done = -1;
    p1 = 64'hx;
    p2 = 64'hx;
    @(negedge clk);
    bus.A     = 32'd0;
    bus.B     = 32'hDEAD_BEEF;
    bus.start = 1'b1;
    for (int j = 0; j <= 70; j++) begin
      @(negedge clk);
      if (bus.done) begin
        done_count++;
        if (first_done < 0) begin
          first_done = j;
          p1 = bus.P;
        end else if (second_done < 0) begin
          second_done = j;
          p2 = bus.P;
        end
      end
      if (j == 0) begin
        bus.A = 32'h1234_5678;
        bus.B = 32'h10;
      end
      if (j == 34) begin
        bus.A = 32'hCAFE_F00D;
        bus.B = 32'h5555_AAAA;
      end
      if (j == 33) begin
        vectors++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_reaccept: busy=%b done=%b, want 1 0", bus.busy, bus.done);
        end
      end
      if (j == 50) begin
        vectors++;
        if (bus.P !== 64'd0) begin
          miscompares++;
          $display("FAIL b2b_p_held: got %h want 0", bus.P);
        end
      end
      if (j == 64) bus.start = 1'b0;
      if (j == 68) begin
        vectors++;
        if (bus.busy !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_idle_after: busy=%b want 0", bus.busy);
        end
      end
    end
    vectors++;
    if (first_done != 32 || p1 !== 64'd0) begin
      miscompares++;
      $display("FAIL b2b_first: done_at=%0d P=%h, want 32 0", first_done, p1);
    end
    vectors++;
    if (second_done != 65 || p2 !== 64'h0000_0001_2345_6780) begin
      miscompares++;
      $display("FAIL b2b_second: done_at=%0d P=%h, want 65 0000000123456780", second_done, p2);
    end
    vectors++;
    if (done_count != 2) begin
      miscompares++;
      $display("FAIL b2b_done_count: got %0d want 2", done_count);
    end
  endtask

  task automatic test_reset_abort;
    @(negedge clk);
    bus.A     = 32'd7;
    bus.B     = 32'd9;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.P !== 64'd0) begin
      miscompares++;
      $display("FAIL abort_outputs: busy=%b done=%b P=%h, want 0 0 0", bus.busy, bus.done, bus.P);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_op("after_abort", 32'd7, 32'd9, 64'h0000_0000_0000_003F, 1'b0);
  endtask

  function automatic logic [31:0] pick_operand();
    int sel;
    sel = $urandom_range(0, 5);
    if (sel == 0) return 32'd0;
    if (sel == 1) return 32'hFFFF_FFFF;
    return $urandom;
  endfunction

  task automatic test_random;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] want;
    for (int i = 0; i < 1000; i++) begin
      a = pick_operand();
      b = pick_operand();
      want = {32'd0, a} * {32'd0, b};
      check_op("rand", a, b, want, (i % 2) == 1);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
